// File: rtl/uart_debug_sequencer_if.sv
// Bus bundle between the debug sequencer, the UART core, the debug target
// and the event requester. master = sequencer, slave = everything around it.
interface uart_debug_sequencer_if;
  // UART receive side
  logic [7:0] rx_byte;
  logic       received;
  logic       recv_error;
  // UART transmit side
  logic [7:0] tx_byte;
  logic       transmit;
  logic       is_transmitting;
  // debug target register port and clock control
  logic [7:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_we;
  logic       dbg_re;
  logic [7:0] dbg_rdata;
  logic       dbg_rvalid;
  logic       clk_en;
  // external event requester sharing the transmitter
  logic       evt_req;
  logic [7:0] evt_byte;
  logic       evt_ack;
  // status
  logic       busy;
  logic [7:0] err_count;

  modport master (
    input  rx_byte, received, recv_error, is_transmitting,
           dbg_rdata, dbg_rvalid, evt_req, evt_byte,
    output tx_byte, transmit, dbg_addr, dbg_wdata, dbg_we, dbg_re,
           clk_en, evt_ack, busy, err_count
  );

  modport slave (
    output rx_byte, received, recv_error, is_transmitting,
           dbg_rdata, dbg_rvalid, evt_req, evt_byte,
    input  tx_byte, transmit, dbg_addr, dbg_wdata, dbg_we, dbg_re,
           clk_en, evt_ack, busy, err_count
  );
endinterface

// File: rtl/uart_debug_sequencer.sv
// UART command sequencer for the debug target: parses R/W/S/G/H frames,
// drives register strobes and the target clock enable, and shares the UART
// transmitter round-robin between command responses and external events.
module uart_debug_sequencer #(
  parameter int FRAME_TIMEOUT = 120000,
  parameter int RD_TIMEOUT    = 16
) (
  input  logic                   iCE_CLK,
  input  logic                   rst,
  uart_debug_sequencer_if.master bus
);
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_S    = 8'h53;
  localparam logic [7:0] OP_G    = 8'h47;
  localparam logic [7:0] OP_H    = 8'h48;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_UNK = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'hEE;
  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);
  localparam int RT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, READ_WAIT, STEP, RESP} cmd_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_BUSY} tx_state_e;

  // command side state
  cmd_state_e      state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      resp_q, resp_d;
  logic [7:0]      step_q, step_d;
  logic [7:0]      err_q, err_d;
  logic [FT_W-1:0] ft_q, ft_d;
  logic [RT_W-1:0] rt_q, rt_d;
  logic            run_q, run_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic            clk_en_q, clk_en_d;
  logic            err_evt;

  // transmit arbiter state
  tx_state_e       tx_state_q, tx_state_d;
  logic            last_evt_q, last_evt_d;
  logic            transmit_q, transmit_d;
  logic            ack_q, ack_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            start_cnt_q, start_cnt_d;
  logic            resp_req, resp_gnt, evt_gnt;

  // Command state register and datapath flops
  always_ff @(posedge iCE_CLK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      step_q   <= '0;
      err_q    <= '0;
      ft_q     <= '0;
      rt_q     <= '0;
      run_q    <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      step_q   <= step_d;
      err_q    <= err_d;
      ft_q     <= ft_d;
      rt_q     <= rt_d;
      run_q    <= run_d;
      we_q     <= we_d;
      re_q     <= re_d;
      clk_en_q <= clk_en_d;
    end
  end

  // Command parsing, target strobes, step counting and error accounting
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    step_d  = step_q;
    ft_d    = ft_q;
    rt_d    = rt_q;
    run_d   = run_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_evt = 1'b0;

    if (bus.recv_error) begin
      // framing error aborts whatever is in flight, run mode is kept
      state_d = IDLE;
      err_evt = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (bus.received) begin
          op_d = bus.rx_byte;
          ft_d = '0;
          case (bus.rx_byte)
            OP_R, OP_W, OP_S: state_d = GET_ADDR;
            OP_G: begin run_d = 1'b1; resp_d = RSP_OK;  state_d = RESP; end
            OP_H: begin run_d = 1'b0; resp_d = RSP_OK;  state_d = RESP; end
            default: begin            resp_d = RSP_UNK; state_d = RESP; end
          endcase
        end
        GET_ADDR: begin
          if (bus.received) begin
            ft_d = '0;
            case (op_q)
              OP_R: begin
                addr_d  = bus.rx_byte;
                re_d    = 1'b1;
                rt_d    = '0;
                state_d = READ_WAIT;
              end
              OP_W: begin
                addr_d  = bus.rx_byte;
                state_d = GET_DATA;
              end
              default: begin
                // step: byte is the cycle count, run mode drops first
                run_d = 1'b0;
                if (bus.rx_byte == 8'd0) begin
                  resp_d  = RSP_OK;
                  state_d = RESP;
                end else begin
                  step_d  = bus.rx_byte;
                  state_d = STEP;
                end
              end
            endcase
          end else if (ft_q == FT_W'(FRAME_TIMEOUT - 1)) begin
            state_d = IDLE;
            err_evt = 1'b1;
          end else begin
            ft_d = ft_q + 1'b1;
          end
        end
        GET_DATA: begin
          if (bus.received) begin
            wdata_d = bus.rx_byte;
            we_d    = 1'b1;
            resp_d  = RSP_OK;
            state_d = RESP;
          end else if (ft_q == FT_W'(FRAME_TIMEOUT - 1)) begin
            state_d = IDLE;
            err_evt = 1'b1;
          end else begin
            ft_d = ft_q + 1'b1;
          end
        end
        READ_WAIT: begin
          // rt_q is 0 in the dbg_re cycle, so rvalid is accepted up to
          // RD_TIMEOUT cycles after the strobe
          if (bus.dbg_rvalid) begin
            resp_d  = bus.dbg_rdata;
            state_d = RESP;
          end else if (rt_q == RT_W'(RD_TIMEOUT)) begin
            resp_d  = RSP_TMO;
            err_evt = 1'b1;
            state_d = RESP;
          end else begin
            rt_d = rt_q + 1'b1;
          end
          if (bus.received) err_evt = 1'b1;
        end
        STEP: begin
          step_d = step_q - 1'b1;
          if (step_q == 8'd1) begin
            resp_d  = RSP_OK;
            state_d = RESP;
          end
          if (bus.received) err_evt = 1'b1;
        end
        RESP: begin
          if (resp_gnt) state_d = IDLE;
          if (bus.received) err_evt = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // several error sources in one cycle count once, saturating at 255
    err_d    = (err_evt && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    // registered so clk_en follows G/H/S one cycle later and is glitch-free
    clk_en_d = run_d | (state_d == STEP);
  end

  // Transmit arbiter registers
  always_ff @(posedge iCE_CLK or posedge rst) begin
    if (rst) begin
      tx_state_q  <= T_IDLE;
      last_evt_q  <= 1'b1;  // event counts as last winner: response wins the first tie
      transmit_q  <= 1'b0;
      ack_q       <= 1'b0;
      tx_byte_q   <= '0;
      start_cnt_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      last_evt_q  <= last_evt_d;
      transmit_q  <= transmit_d;
      ack_q       <= ack_d;
      tx_byte_q   <= tx_byte_d;
      start_cnt_q <= start_cnt_d;
    end
  end

  // Round-robin grant between pending response and external event
  always_comb begin
    tx_state_d  = tx_state_q;
    last_evt_d  = last_evt_q;
    transmit_d  = 1'b0;
    ack_d       = 1'b0;
    tx_byte_d   = tx_byte_q;
    start_cnt_d = start_cnt_q;
    evt_gnt     = 1'b0;
    resp_gnt    = 1'b0;
    // a response being aborted this cycle must not be sent
    resp_req    = (state_q == RESP) && !bus.recv_error;

    case (tx_state_q)
      T_IDLE: if (!bus.is_transmitting && (resp_req || bus.evt_req)) begin
        evt_gnt     = (resp_req && bus.evt_req) ? !last_evt_q : bus.evt_req;
        resp_gnt    = !evt_gnt;
        transmit_d  = 1'b1;
        ack_d       = evt_gnt;
        tx_byte_d   = evt_gnt ? bus.evt_byte : resp_q;
        last_evt_d  = evt_gnt;
        start_cnt_d = 1'b0;
        tx_state_d  = T_START;
      end
      T_START: begin
        // UART that never raises busy within 2 cycles is taken as done
        if (bus.is_transmitting || start_cnt_q) tx_state_d = T_BUSY;
        else                                    start_cnt_d = 1'b1;
      end
      T_BUSY: if (!bus.is_transmitting) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  assign bus.tx_byte   = tx_byte_q;
  assign bus.transmit  = transmit_q;
  assign bus.evt_ack   = ack_q;
  assign bus.dbg_addr  = addr_q;
  assign bus.dbg_wdata = wdata_q;
  assign bus.dbg_we    = we_q;
  assign bus.dbg_re    = re_q;
  assign bus.clk_en    = clk_en_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_uart_debug_sequencer.sv
// Scoreboard bench for uart_debug_sequencer: directed frames push expected
// UART bytes / target strobes into queues; a negedge monitor pops and checks.
module tb_uart_debug_sequencer;
  localparam int FT     = 400;
  localparam int TX_LEN = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_debug_sequencer_if bus();

  uart_debug_sequencer #(.FRAME_TIMEOUT(FT), .RD_TIMEOUT(16)) dut (
    .iCE_CLK (clk),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct { logic [7:0] b; logic evt; } tx_exp_t;
  tx_exp_t    tx_q[$];
  logic [15:0] we_q[$];
  logic [7:0]  re_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tx_left = 0;
  int   rd_delay = 0;
  int   evt_acked = 0;
  int   evt_total = 0;
  logic uart_hold = 1'b0;
  logic rd_respond = 1'b1;

  assign bus.is_transmitting = (tx_left > 0) || uart_hold;
  assign bus.evt_req         = (evt_acked < evt_total);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_tx(input logic [7:0] b, input logic evt);
    tx_exp_t e;
    e.b = b;
    e.evt = evt;
    tx_q.push_back(e);
  endtask

  // Monitor plus UART / event / target models
  always @(negedge clk) begin
    if (rst) begin
      tx_left   = 0;
      rd_delay  = 0;
      evt_acked = 0;
      bus.dbg_rvalid = 1'b0;
    end else begin
      if (bus.transmit) begin
        if (tx_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got tx_byte %0h, expected no transmit", bus.tx_byte);
        end else begin
          tx_exp_t e;
          e = tx_q.pop_front();
          check("tx_byte", {24'h0, bus.tx_byte}, {24'h0, e.b});
          check("evt_ack_with_tx", {31'h0, bus.evt_ack}, {31'h0, e.evt});
          check("tx_while_busy", {31'h0, bus.is_transmitting}, 32'h0);
        end
      end else if (bus.evt_ack) begin
        n_tests++; n_fail++;
        $display("FAIL evt_ack_no_tx: got evt_ack 1, expected 0");
      end
      if (bus.dbg_we) begin
        if (we_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL we_unexpected: got addr %0h data %0h, expected no write", bus.dbg_addr, bus.dbg_wdata);
        end else begin
          logic [15:0] w;
          w = we_q.pop_front();
          check("dbg_write", {16'h0, bus.dbg_addr, bus.dbg_wdata}, {16'h0, w});
        end
      end
      if (bus.dbg_re) begin
        if (re_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL re_unexpected: got addr %0h, expected no read", bus.dbg_addr);
        end else begin
          logic [7:0] a;
          a = re_q.pop_front();
          check("dbg_read_addr", {24'h0, bus.dbg_addr}, {24'h0, a});
        end
      end
      // UART: busy for TX_LEN cycles starting the cycle transmit is seen
      if (tx_left > 0) tx_left--;
      if (bus.transmit) tx_left = TX_LEN;
      if (bus.evt_ack) evt_acked++;
      // target: rvalid with 3C, 3 cycles after dbg_re
      bus.dbg_rvalid = 1'b0;
      if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) begin
          bus.dbg_rvalid = 1'b1;
          bus.dbg_rdata  = 8'h3C;
        end
      end
      if (bus.dbg_re && rd_respond) rd_delay = 3;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte  = b;
    bus.received = 1'b1;
    @(negedge clk);
    bus.received = 1'b0;
  endtask

  task automatic pulse_rxerr();
    @(negedge clk);
    bus.recv_error = 1'b1;
    @(negedge clk);
    bus.recv_error = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || bus.busy || bus.is_transmitting) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n >= 300), 32'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    evt_total = 0;
    uart_hold = 1'b0;
    tx_q.delete();
    we_q.delete();
    re_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Clock count with clk_en high, and number of separate high runs
  task automatic count_clk_en(input int cycles, output int ones, output int runs);
    logic prev;
    prev = 1'b0;
    ones = 0;
    runs = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.clk_en) ones++;
      if (bus.clk_en && !prev) runs++;
      prev = bus.clk_en;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, runs, n;
    bus.rx_byte    = 8'h00;
    bus.received   = 1'b0;
    bus.recv_error = 1'b0;
    bus.evt_byte   = 8'hE1;
    bus.dbg_rdata  = 8'h00;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_bytes", {bus.tx_byte, bus.dbg_addr, bus.dbg_wdata, bus.err_count}, 32'h0);
    check("reset_bits", {26'h0, bus.transmit, bus.dbg_we, bus.dbg_re, bus.clk_en, bus.busy, bus.evt_ack}, 32'h0);
    rst = 1'b0;

    // arbitration: response pending with event pending, UART held busy
    uart_hold = 1'b1;
    send(8'h47);
    check("G_clk_en", {31'h0, bus.clk_en}, 32'h1);
    exp_tx(8'h4B, 1'b0);
    exp_tx(8'hE1, 1'b1);
    exp_tx(8'h4B, 1'b0);
    exp_tx(8'hE1, 1'b1);
    evt_total = 2;
    repeat (4) @(negedge clk);
    check("resp_held", {31'h0, bus.busy}, 32'h1);
    uart_hold = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin @(negedge clk); n++; end
    check("first_grant_timeout", 32'(n >= 20), 32'h0);
    send(8'h48);
    check("H_clk_en", {31'h0, bus.clk_en}, 32'h0);
    drain("arb");
    check("evt_ack_count", evt_acked, 32'd2);

    // write
    we_q.push_back({8'h10, 8'hA5});
    exp_tx(8'h4B, 1'b0);
    send(8'h57); send(8'h10); send(8'hA5);
    drain("write");
    check("write_seen", we_q.size(), 32'd0);

    // read with rvalid
    re_q.push_back(8'h22);
    exp_tx(8'h3C, 1'b0);
    send(8'h52); send(8'h22);
    drain("read");
    check("read_err", {24'h0, bus.err_count}, 32'h0);

    // read without rvalid
    rd_respond = 1'b0;
    re_q.push_back(8'h33);
    exp_tx(8'hEE, 1'b0);
    send(8'h52); send(8'h33);
    drain("read_tmo");
    check("read_tmo_err", {24'h0, bus.err_count}, 32'h1);
    rd_respond = 1'b1;

    // step 5
    exp_tx(8'h4B, 1'b0);
    send(8'h53); send(8'h05);
    count_clk_en(20, ones, runs);
    check("step5_cycles", ones, 32'd5);
    check("step5_runs", runs, 32'd1);
    drain("step5");

    // step 0
    exp_tx(8'h4B, 1'b0);
    send(8'h53); send(8'h00);
    count_clk_en(10, ones, runs);
    check("step0_cycles", ones, 32'd0);
    drain("step0");

    // unknown opcode
    exp_tx(8'h3F, 1'b0);
    send(8'h5A);
    drain("unknown");
    check("unknown_clk_en", {31'h0, bus.clk_en}, 32'h0);

    // errors from a clean counter
    do_reset();
    check("err_after_reset", {24'h0, bus.err_count}, 32'h0);
    send(8'h57);
    repeat (FT - 3) @(negedge clk);
    check("ft_not_yet", {31'h0, bus.busy}, 32'h1);
    repeat (5) @(negedge clk);
    check("ft_idle", {31'h0, bus.busy}, 32'h0);
    check("ft_err", {24'h0, bus.err_count}, 32'h1);

    send(8'h57); send(8'h10);
    check("rxerr_busy_before", {31'h0, bus.busy}, 32'h1);
    pulse_rxerr();
    check("rxerr_idle", {31'h0, bus.busy}, 32'h0);
    check("rxerr_err", {24'h0, bus.err_count}, 32'h2);
    repeat (5) @(negedge clk);

    uart_hold = 1'b1;
    exp_tx(8'h3F, 1'b0);
    send(8'h5A);
    repeat (2) @(negedge clk);
    check("overrun_in_resp", {31'h0, bus.busy}, 32'h1);
    send(8'h52);
    check("overrun_err", {24'h0, bus.err_count}, 32'h3);
    uart_hold = 1'b0;
    drain("overrun");

    for (int i = 0; i < 300; i++) pulse_rxerr();
    check("err_saturate", {24'h0, bus.err_count}, 32'hFF);

    // reset mid-step
    do_reset();
    send(8'h53); send(8'hFF);
    repeat (10) @(negedge clk);
    check("step_ff_active", {31'h0, bus.clk_en}, 32'h1);
    #2 rst = 1'b1;
    #1 check("rst_midstep", {29'h0, bus.clk_en, bus.busy, bus.transmit}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("post_rst_clk_en", {30'h0, bus.clk_en, bus.busy}, 32'h0);
    check("tx_queue_empty", tx_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_debug_sequencer.md
Name: uart_debug_sequencer

Overview:
Command sequencer between the UART core and the debug target. It parses multi-byte command frames from the UART receive side and issues register read/write strobes and clock-enable (run/halt/step) control to the target. It shares the single UART transmitter between its own command responses and an external event requester, using round-robin arbitration.

Parameters:
FRAME_TIMEOUT, 120000, max idle cycles between bytes of one frame (10 ms at 12 MHz); then the partial frame is discarded
RD_TIMEOUT, 16, max cycles from dbg_re to dbg_rvalid

Ports:
iCE_CLK  in  1  system clock, 12 MHz
rst  in  1  asynchronous reset, active-high
rx_byte  in  8  byte from UART; valid when received=1
received  in  1  one-cycle pulse, new rx_byte
recv_error  in  1  one-cycle pulse, UART framing error
tx_byte  out  8  byte to UART; stable while transmit=1 and one cycle after
transmit  out  1  one-cycle pulse, start UART send
is_transmitting  in  1  UART transmitter busy
dbg_addr  out  8  target register address
dbg_wdata  out  8  target write data
dbg_we  out  1  one-cycle write strobe
dbg_re  out  1  one-cycle read strobe
dbg_rdata  in  8  read data; valid when dbg_rvalid=1
dbg_rvalid  in  1  read-data valid pulse
clk_en  out  1  target clock enable
evt_req  in  1  level; event byte pending; evt_byte held until ack
evt_byte  in  8  event byte to send
evt_ack  out  1  one-cycle pulse in the same cycle transmit carries evt_byte
busy  out  1  command FSM not in IDLE
err_count  out  8  saturating error counter

Behaviour:
- Reset values: all outputs 0, FSMs in IDLE, run mode off, round-robin pointer set to "response".
- Commands (first byte): 'R'=0x52 addr; 'W'=0x57 addr data; 'S'=0x53 n; 'G'=0x47; 'H'=0x48. Any other opcode: reply 0x3F, no target action.
- Command FSM states: IDLE, GET_ADDR, GET_DATA, READ_WAIT, STEP, RESP.
- IDLE takes the opcode. G, H and unknown opcodes go directly to RESP. R, W and S go to GET_ADDR; for S the byte taken there is n.
- W: dbg_we pulses in the cycle after the data byte's received pulse, with dbg_addr and dbg_wdata valid. Reply 0x4B.
- R: dbg_re pulses in the cycle after the addr byte's received pulse. FSM moves to READ_WAIT.
  - dbg_rvalid within RD_TIMEOUT cycles: capture dbg_rdata and reply with it.
  - No dbg_rvalid in time: reply 0xEE and increment err_count.
- G: run mode set, clk_en=1 from the next cycle. H: run mode cleared, clk_en=0 from the next cycle. Both reply 0x4B.
- S n: run mode is cleared, then clk_en=1 for exactly n consecutive cycles, starting the cycle after n is received. Reply 0x4B after the last enabled cycle. n=0: no clk_en pulse, reply immediately. Maximum n is 255.
- RESP: the response byte is held pending until the arbiter sends it, then the FSM returns to IDLE.
- Received byte while FSM is in READ_WAIT, STEP or RESP: byte dropped, err_count incremented (overrun).
- recv_error in any state: abort to IDLE, no reply, err_count incremented. Run mode is unchanged. A step in progress is truncated: clk_en=0 next cycle.
- Frame timeout: in GET_ADDR or GET_DATA with no received pulse for FRAME_TIMEOUT cycles: return to IDLE, err_count incremented.
- err_count saturates at 255. Multiple error events in one cycle count once.
- TX arbiter states: T_IDLE, T_START, T_BUSY.
  - A grant is possible only in T_IDLE with is_transmitting=0.
  - Only one requester pending: grant it.
  - Both pending: grant the one not granted last. Then flip the pointer.
  - Grant cycle: transmit=1 and tx_byte set; evt_ack=1 if the event was granted. Then go to T_START.
  - T_START: wait for is_transmitting=1. If it is not seen within 2 cycles, treat the send as complete. Then go to T_BUSY.
  - T_BUSY: wait for is_transmitting=0, then go to T_IDLE.
- Reset mid-operation: everything returns to reset values immediately (asynchronous), including clk_en=0 and the pending response discarded.

Test Plan:
- Write: bytes 57,10,A5 → one dbg_we pulse with dbg_addr=10, dbg_wdata=A5; one transmit with tx_byte=4B.
- Read: bytes 52,22; bench returns dbg_rvalid with dbg_rdata=3C 3 cycles after dbg_re → transmit tx_byte=3C. Repeat with no dbg_rvalid → tx_byte=EE, err_count=1.
- Step and run: bytes 53,05 → clk_en high for exactly 5 cycles, then tx_byte=4B. Bytes 53,00 → no clk_en, tx_byte=4B. G then H → clk_en 1 then 0, two 4B replies.
- Arbitration: evt_req=1 with evt_byte=E1 held while the 'G' response is pending → bytes sent alternate E1/4B (response first after reset). evt_ack pulses exactly once per E1 send; no transmit while is_transmitting=1.
- Errors: byte 57 then 120000 idle cycles → IDLE, err_count=1, no reply. recv_error mid-frame → IDLE, err_count=2. Overrun during RESP → count +1. Force 300 errors → err_count=FF.
- Reset mid-step: rst asserted during S FF → clk_en=0, busy=0 and transmit=0 in the same cycle; no reply after rst is released.
